// File: rtl/sha256_pkg.sv
// Shared constants, FSM states and byte-mask helpers for the SHA-256 front end.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int WORD_W      = 32;
  localparam int LEN_W       = 64;
  localparam int NUM_WORDS   = BLOCK_W / WORD_W;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_WORD_HI = 14;
  localparam int LEN_WORD_LO = 15;

  typedef enum logic [1:0] {FILL, PAD, PAD2, EMIT} state_t;

  // Byte counts above 4 behave as a full word.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] nb);
    return (nb > 3'd4) ? 3'd4 : nb;
  endfunction

  // Keeps the leading nb bytes (big-endian) of a word.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nb);
    logic [2:0] n;
    n = clamp_bytes(nb);
    return ~({WORD_W{1'b1}} >> {n, 3'b000});
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Packs a big-endian 32-bit word stream into FIPS 180-4 padded 512-bit blocks
// and hands them to the core one at a time with first/last flags.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_first,
  output logic               block_last
);

  // Word i of the block lives in slot NUM_WORDS-1-i so slot 15 lands in bits 511:480.
  localparam int HI_SLOT = NUM_WORDS - 1 - LEN_WORD_HI;
  localparam int LO_SLOT = NUM_WORDS - 1 - LEN_WORD_LO;

  state_t                               state_q, state_d, ret_q, ret_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]     buf_q, buf_d;
  logic [3:0]                           idx_q, idx_d, pad_idx_q, pad_idx_d;
  logic [1:0]                           pad_byte_q, pad_byte_d;
  logic [LEN_W-1:0]                     len_q, len_d;
  logic                                 first_q, first_d, last_q, last_d;
  logic [2:0]                           nb;
  logic [WORD_W-1:0]                    pad_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      ret_q      <= FILL;
      buf_q      <= '0;
      idx_q      <= '0;
      pad_idx_q  <= '0;
      pad_byte_q <= '0;
      len_q      <= '0;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      pad_idx_q  <= pad_idx_d;
      pad_byte_q <= pad_byte_d;
      len_q      <= len_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    pad_idx_d  = pad_idx_q;
    pad_byte_d = pad_byte_q;
    len_d      = len_q;
    first_d    = first_q;
    last_d     = last_q;
    nb         = clamp_bytes(in_bytes);
    pad_word   = {PAD_BYTE, 24'h0} >> {pad_byte_q, 3'b000};

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          idx_d = idx_q + 4'd1;
          if (in_last) begin
            buf_d[~idx_q] = in_data & byte_mask(nb);
            len_d         = len_q + LEN_W'({nb, 3'b000});
            // A full last word pushes the pad byte into the next word; the
            // 4-bit index wraps to 0 when that next word is in a fresh block.
            pad_idx_d     = (nb == 3'd4) ? idx_q + 4'd1 : idx_q;
            pad_byte_d    = (nb == 3'd4) ? 2'd0 : nb[1:0];
            if (nb == 3'd4 && idx_q == 4'd15) begin
              state_d = EMIT;
              ret_d   = PAD;
            end else begin
              state_d = PAD;
            end
          end else begin
            buf_d[~idx_q] = in_data;
            len_d         = len_q + LEN_W'(WORD_W);
            if (idx_q == 4'd15) begin
              state_d = EMIT;
              ret_d   = FILL;
            end
          end
        end
      end
      PAD: begin
        buf_d[~pad_idx_q] = buf_q[~pad_idx_q] | pad_word;
        state_d           = EMIT;
        if (pad_idx_q <= 4'd13) begin
          buf_d[HI_SLOT] = len_q[LEN_W-1:WORD_W];
          buf_d[LO_SLOT] = len_q[WORD_W-1:0];
          last_d         = 1'b1;
          ret_d          = FILL;
        end else begin
          ret_d = PAD2;
        end
      end
      PAD2: begin
        buf_d          = '0;
        buf_d[HI_SLOT] = len_q[LEN_W-1:WORD_W];
        buf_d[LO_SLOT] = len_q[WORD_W-1:0];
        last_d         = 1'b1;
        state_d        = EMIT;
        ret_d          = FILL;
      end
      EMIT: begin
        if (block_ready) begin
          buf_d   = '0;
          idx_d   = '0;
          state_d = ret_q;
          first_d = 1'b0;
          if (last_q) begin
            len_d   = '0;
            first_d = 1'b1;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == EMIT);
  assign block       = buf_q;
  assign block_first = first_q;
  assign block_last  = last_q;

endmodule
